// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: round-robin share of one classic Wishbone master between imem and dmem.
module wb_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_req,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  imem_resp,
  output logic                  imem_err,
  input  logic                  dmem_req,
  input  logic                  dmem_cmd,
  input  logic [1:0]            dmem_width,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_resp,
  output logic                  dmem_err,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [3:0]            wb_sel,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0] wb_data_out,
  input  logic [DATA_WIDTH-1:0] wb_data_in,
  input  logic                  wb_ack
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  localparam logic [31:0] TO = 32'(TIMEOUT_CYCLES);
  state_t state, state_n;
  logic last, last_n, own, own_n, pick_d, tout, done;
  logic cyc_n, we_n, iresp_n, ierr_n, dresp_n, derr_n;
  logic [31:0] cnt, cnt_n, cnt_inc;
  logic [3:0] sel_n, dsel;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] dout_n, ddata, irdata_n, drdata_n, cap;
  // last/own: 0 = imem, 1 = dmem; on a tie the side that did not go last wins
  assign pick_d = dmem_req & (~imem_req | ~last);
  assign cnt_inc = cnt + 32'd1;
  assign tout = (TO != 32'd0) && (cnt_inc == TO);
  assign done = wb_ack | tout;
  assign cap = wb_ack ? wb_data_in : '0;
  assign dsel = dmem_width == 2'b00 ? 4'b0001 << dmem_addr[1:0] :
                dmem_width == 2'b01 ? (dmem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign ddata = dmem_width == 2'b00 ? {4{dmem_wdata[7:0]}} :
                 dmem_width == 2'b01 ? {2{dmem_wdata[15:0]}} : dmem_wdata;
  always_comb begin
    state_n = state;
    last_n = last;
    own_n = own;
    cnt_n = cnt;
    cyc_n = wb_cyc;
    we_n = wb_we;
    sel_n = wb_sel;
    addr_n = wb_addr;
    dout_n = wb_data_out;
    irdata_n = imem_rdata;
    drdata_n = dmem_rdata;
    iresp_n = 1'b0;
    ierr_n = 1'b0;
    dresp_n = 1'b0;
    derr_n = 1'b0;
    case (state)
      IDLE: if (imem_req | dmem_req) begin
        state_n = BUS;
        own_n = pick_d;
        last_n = pick_d;
        cnt_n = '0;
        cyc_n = 1'b1;
        we_n = pick_d & dmem_cmd;
        sel_n = pick_d ? dsel : 4'b1111;
        addr_n = pick_d ? dmem_addr : imem_addr;
        dout_n = pick_d ? ddata : '0;
      end
      BUS: if (done) begin
        state_n = RESP;
        cyc_n = 1'b0;
        we_n = 1'b0;
        sel_n = 4'b0000;
        iresp_n = ~own;
        dresp_n = own;
        ierr_n = ~own & ~wb_ack;
        derr_n = own & ~wb_ack;
        irdata_n = own ? imem_rdata : cap;
        drdata_n = own ? cap : dmem_rdata;
      end else cnt_n = cnt_inc;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      own <= 1'b0;
      cnt <= '0;
      wb_cyc <= 1'b0;
      wb_stb <= 1'b0;
      wb_we <= 1'b0;
      wb_sel <= '0;
      wb_addr <= '0;
      wb_data_out <= '0;
      imem_rdata <= '0;
      imem_resp <= 1'b0;
      imem_err <= 1'b0;
      dmem_rdata <= '0;
      dmem_resp <= 1'b0;
      dmem_err <= 1'b0;
    end else begin
      state <= state_n;
      last <= last_n;
      own <= own_n;
      cnt <= cnt_n;
      wb_cyc <= cyc_n;
      wb_stb <= cyc_n;
      wb_we <= we_n;
      wb_sel <= sel_n;
      wb_addr <= addr_n;
      wb_data_out <= dout_n;
      imem_rdata <= irdata_n;
      imem_resp <= iresp_n;
      imem_err <= ierr_n;
      dmem_rdata <= drdata_n;
      dmem_resp <= dresp_n;
      dmem_err <= derr_n;
    end
  end
endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Shares one Wishbone master port between the core's instruction-fetch (imem) and load/store (dmem) request/response interfaces.
- Used when only the primary memory bus is available (second data bus disabled). It sits between ssrv_top and the Controller core bus.
- Grants requesters round-robin, runs one classic single-beat Wishbone cycle per grant, and returns a one-cycle resp pulse to the granted requester.
- Provides byte-lane select generation and a bus timeout that reports err.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in BUS without ack before the arbiter aborts with err; 0 disables the timeout.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width; fixed at 32 (select logic assumes 4 lanes).

Ports:
- clk  in  1  core clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  in  1  fetch request; held high until imem_resp
- imem_addr  in  32  fetch address
- imem_rdata  out  32  fetch data, valid with imem_resp
- imem_resp  out  1  one-cycle completion pulse
- imem_err  out  1  timeout flag, valid with imem_resp
- dmem_req  in  1  data request; held high until dmem_resp
- dmem_cmd  in  1  1=write, 0=read
- dmem_width  in  2  2'b10 word, 2'b01 half, 2'b00 byte, 2'b11 treated as word
- dmem_addr  in  32  data address
- dmem_wdata  in  32  write data, right-aligned
- dmem_rdata  out  32  raw read word, valid with dmem_resp
- dmem_resp  out  1  one-cycle completion pulse
- dmem_err  out  1  timeout flag, valid with dmem_resp
- wb_cyc  out  1  bus cycle
- wb_stb  out  1  strobe; always equals wb_cyc
- wb_we  out  1  write enable
- wb_sel  out  4  byte lanes
- wb_addr  out  32  address
- wb_data_out  out  32  write data
- wb_data_in  in  32  read data
- wb_ack  in  1  slave acknowledge

Behaviour:
- Reset behaviour: with rst high at an edge, every output is registered to 0, state goes to IDLE and last_grant goes to dmem (imem wins the first tie). This applies at any point, including mid-cycle: wb_cyc drops, no resp is issued, and the requester must re-request.
- Every output is a register; there is no combinational path from an input to an output.
- States: IDLE, BUS, RESP.
- IDLE, no request: remain in IDLE.
- IDLE, exactly one requester high: grant it.
- IDLE, both requesters high: grant the one not equal to last_grant, then update last_grant.
- On grant, latch the owner, address, we, sel and data, set wb_cyc=wb_stb=1, clear the timeout counter and move to BUS.
- Grant in an IDLE cycle N puts wb_cyc high from cycle N+1.
- imem grant fields: we=0, sel=4'b1111, wb_data_out=0.
- dmem sel by width:
  - word: 4'b1111.
  - half: addr[1] ? 4'b1100 : 4'b0011.
  - byte: 4'b0001 << addr[1:0].
- dmem write data: byte is replicated ×4 (wdata[7:0]); half is replicated ×2 (wdata[15:0]); word is passed through.
- The address is passed through unmodified; there is no alignment check.
- BUS, wb_ack sampled high: capture wb_data_in (for writes too), clear wb_cyc/wb_stb/wb_we/wb_sel, set owner resp=1 and err=0, go to RESP.
- BUS, no ack: increment the counter. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES, drop wb_cyc, set owner resp=1, err=1, rdata=0, go to RESP.
- BUS, ack and timeout in the same cycle: ack wins.
- RESP: resp is high for exactly this one cycle. Requests are not sampled in RESP, so a still-high req cannot re-grant. Clear resp/err and go to IDLE.
- rdata holds its value until the next completion for that port.
- Zero-wait slave (ack in first wb_cyc cycle): request sampled at N, resp at N+2, next grant possible at N+3.
- A wb_ack seen outside BUS is ignored.
- The non-granted requester's resp stays 0.
- Input changes during BUS do not affect the bus fields, which are latched.

Test Plan:
- imem read, imem_addr=0x100, slave acks on the first cyc cycle with 0xDEADBEEF -> wb_cyc high 1 cycle, wb_sel=4'hF, wb_we=0, imem_resp pulses 1 cycle later with imem_rdata=0xDEADBEEF, imem_err=0.
- dmem byte write, addr=0x203, wdata=0x000000A5 -> wb_we=1, wb_sel=4'b1000, wb_data_out=0xA5A5A5A5; half write at addr 0x202, wdata=0x1234 -> sel=4'b1100, data=0x12341234.
- Both requesters held high continuously after reset -> grants alternate imem, dmem, imem, dmem; each resp pulses exactly once per grant.
- TIMEOUT_CYCLES=4, slave never acks -> wb_cyc drops after 4 BUS cycles, dmem_resp=1, dmem_err=1, dmem_rdata=0; the next request proceeds normally.
- rst asserted 2 cycles into a BUS wait, then ack arrives -> all outputs 0 on the edge following rst, no resp issued, late ack ignored.
- Slave with 3 wait states, back-to-back imem requests -> the request is re-sampled only in IDLE after the RESP cycle; no duplicate cycle while imem_req remains high during RESP.
